// File: rtl/press_display_if.sv
// Display-stage bus: the binary value in, the multiplexed seven-segment drive
// and the converter busy flag out.
interface press_display_if;
  logic [7:0] value;
  logic [7:0] segments;
  logic [3:0] anodes;
  logic       busy;

  modport master (output value, input segments, anodes, busy);
  modport slave  (input value, output segments, anodes, busy);
endinterface

// File: rtl/press_display.sv
// press_display: sequential shift-add-3 binary-to-BCD converter feeding a
// 4-digit common-anode multiplexed seven-segment scanner with leading-zero
// blanking. All outputs are registered.
module press_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input logic        clock,
  input logic        reset,
  press_display_if.slave bus
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t          state;
  logic [7:0]      bin;
  logic [7:0]      last_value;
  logic [9:0]      scratch;     // {hundreds[1:0], tens[3:0], units[3:0]}
  logic [7:0]      adj_lo;      // tens/units after the add-3 correction
  logic [3:0]      bit_cnt;
  logic [1:0]      hun;
  logic [3:0]      ten;
  logic [3:0]      uni;

  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic [1:0]      idx_nxt;
  logic [7:0]      seg_nxt;
  logic [3:0]      an_nxt;

  // Active-low g..a pattern for one decimal digit.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction on units and tens; hundreds never exceeds 2 so it needs none.
  always_comb begin
    adj_lo = scratch[7:0];
    if (scratch[3:0] >= 4'd5) adj_lo[3:0] = scratch[3:0] + 4'd3;
    if (scratch[7:4] >= 4'd5) adj_lo[7:4] = scratch[7:4] + 4'd3;
  end

  // Converter FSM: capture on change, 8 shifts, one settle cycle, then commit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bin        <= '0;
      last_value <= '0;
      scratch    <= '0;
      bit_cnt    <= '0;
      hun        <= '0;
      ten        <= '0;
      uni        <= '0;
      bus.busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.value != last_value) begin
            bin        <= bus.value;
            scratch    <= '0;
            bit_cnt    <= '0;
            last_value <= bus.value;
            bus.busy   <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          // The 8th shift lands one cycle before COMMIT is entered, so busy
          // covers capture + 8 shifts + transition + commit = 10 cycles.
          if (bit_cnt == 4'd8) begin
            state <= COMMIT;
          end else begin
            scratch <= {scratch[8], adj_lo, bin[7]};
            bin     <= {bin[6:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        COMMIT: begin
          hun      <= scratch[9:8];
          ten      <= scratch[7:4];
          uni      <= scratch[3:0];
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Next digit index and its drive pattern, with leading-zero blanking.
  always_comb begin
    idx_nxt = (cnt == CNT_MAX) ? idx + 2'd1 : idx;
    an_nxt  = 4'hF;
    seg_nxt = 8'hFF;
    case (idx_nxt)
      2'd0: begin
        an_nxt  = 4'b1110;
        seg_nxt = {1'b1, seg_of(uni)};
      end
      2'd1: begin
        an_nxt  = 4'b1101;
        seg_nxt = (hun == 2'd0 && ten == 4'd0) ? 8'hFF : {1'b1, seg_of(ten)};
      end
      2'd2: begin
        an_nxt  = 4'b1011;
        seg_nxt = (hun == 2'd0) ? 8'hFF : {1'b1, seg_of({2'b00, hun})};
      end
      default: begin
        an_nxt  = 4'hF;
        seg_nxt = 8'hFF;
      end
    endcase
  end

  // Refresh scanner: dwell counter, digit index and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      idx          <= '0;
      bus.anodes   <= 4'hF;
      bus.segments <= 8'hFF;
    end else begin
      cnt          <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
      idx          <= idx_nxt;
      bus.anodes   <= an_nxt;
      bus.segments <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_press_display.sv
// Bench for press_display: reset/idle scan, table-driven conversions,
// mid-conversion change, reset mid-conversion, random values against a
// decimal model, and a fast-refresh rotation check.
module tb_press_display;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  press_display_if bus4();
  press_display_if bus2();

  press_display #(.REFRESH_DIV(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4.slave));
  press_display #(.REFRESH_DIV(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2.slave));

  logic [6:0] pat [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    logic [7:0] v;
    logic [7:0] eu;
    logic [7:0] et;
    logic [7:0] eh;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Decimal model: digit patterns and blanking straight from the number.
  task automatic model(input int v, output logic [7:0] eu, output logic [7:0] et,
                       output logic [7:0] eh);
    int h, t, u;
    h = v / 100; t = (v / 10) % 10; u = v % 10;
    eu = {1'b1, pat[u]};
    et = (h == 0 && t == 0) ? 8'hFF : {1'b1, pat[t]};
    eh = (h == 0) ? 8'hFF : {1'b1, pat[h]};
  endtask

  task automatic set_value(input logic [7:0] v);
    bus4.value = v;
    bus2.value = v;
  endtask

  task automatic wait_rise(output bit ok);
    int k = 0;
    while (bus4.busy !== 1'b1 && k < 20) begin @(negedge clock); k++; end
    ok = (bus4.busy === 1'b1);
    if (!ok) chk("busy_rise_timeout", 32'd0, 32'd1);
  endtask

  // Counts high samples starting at the current one; returns on the first low.
  task automatic wait_fall(output int len);
    len = 0;
    while (bus4.busy === 1'b1 && len < 40) begin len++; @(negedge clock); end
  endtask

  task automatic frame(output logic [7:0] su, output logic [7:0] st,
                       output logic [7:0] sh, output int bad);
    su = 'x; st = 'x; sh = 'x; bad = 0;
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      case (bus4.anodes)
        4'b1110: su = bus4.segments;
        4'b1101: st = bus4.segments;
        4'b1011: sh = bus4.segments;
        4'b1111: if (bus4.segments !== 8'hFF) bad++;
        default: bad++;
      endcase
      @(negedge clock);
    end
  endtask

  task automatic conv_check(input string nm, input logic [7:0] v, input logic [7:0] eu,
                            input logic [7:0] et, input logic [7:0] eh);
    bit ok;
    int len, bad;
    logic [7:0] su, st, sh;
    set_value(v);
    wait_rise(ok);
    if (ok) begin
      wait_fall(len);
      chk({nm, "_busy_len"}, len, 10);
    end
    frame(su, st, sh, bad);
    chk({nm, "_units"}, su, eu);
    chk({nm, "_tens"}, st, et);
    chk({nm, "_hund"}, sh, eh);
    chk({nm, "_dark"}, bad, 0);
  endtask

  function automatic logic [3:0] rot(input logic [3:0] a);
    case (a)
      4'b1110: rot = 4'b1101;
      4'b1101: rot = 4'b1011;
      4'b1011: rot = 4'b1111;
      default: rot = 4'b1110;
    endcase
  endfunction

  // Checks full anode runs: dwell length, rotation order and segment content.
  task automatic check_runs(input string nm, input int div, input logic [3:0] an [$],
                            input logic [7:0] sg [$], input logic [7:0] eu,
                            input logic [7:0] et, input logic [7:0] eh);
    int s = 1, j, nfull = 0, bad;
    logic [7:0] es;
    while (s < an.size() && an[s] == an[0]) s++;
    while (s < an.size()) begin
      j = s;
      while (j < an.size() && an[j] == an[s]) j++;
      if (j >= an.size()) break;
      chk({nm, "_dwell"}, j - s, div);
      chk({nm, "_order"}, an[s], rot(an[s-1]));
      case (an[s])
        4'b1110: es = eu;
        4'b1101: es = et;
        4'b1011: es = eh;
        default: es = 8'hFF;
      endcase
      bad = 0;
      for (int k = s; k < j; k++) if (sg[k] !== es) bad++;
      chk({nm, "_segs"}, bad, 0);
      nfull++;
      s = j;
    end
    chk({nm, "_enough_runs"}, (nfull >= 8) ? 1 : 0, 1);
  endtask

  initial begin
    logic [3:0] aq [$];
    logic [7:0] sq [$];
    logic [7:0] eu, et, eh, su, st, sh;
    int len, bad, busy_seen, v, cur;
    bit ok;

    tbl[0] = '{8'd255, 8'h92, 8'h92, 8'hA4};
    tbl[1] = '{8'd7,   8'hF8, 8'hFF, 8'hFF};
    tbl[2] = '{8'd40,  8'hC0, 8'h99, 8'hFF};
    tbl[3] = '{8'd123, 8'hB0, 8'hA4, 8'hF9};
    tbl[4] = '{8'd100, 8'hC0, 8'hC0, 8'hF9};
    tbl[5] = '{8'd10,  8'hC0, 8'hF9, 8'hFF};

    // Reset state
    set_value(8'd0);
    repeat (3) @(negedge clock);
    chk("rst_segments", bus4.segments, 8'hFF);
    chk("rst_anodes", bus4.anodes, 4'hF);
    chk("rst_busy", bus4.busy, 1'b0);
    chk("rst2_anodes", bus2.anodes, 4'hF);

    // Idle scan with value 0
    reset = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 44; i++) begin
      @(negedge clock);
      aq.push_back(bus4.anodes);
      sq.push_back(bus4.segments);
      if (bus4.busy === 1'b1) busy_seen++;
    end
    chk("first_anodes", aq[0], 4'b1110);
    chk("first_segments", sq[0], 8'hC0);
    chk("idle_busy_never", busy_seen, 0);
    check_runs("idle", 4, aq, sq, 8'hC0, 8'hFF, 8'hFF);

    // Table-driven conversions
    for (int i = 0; i < 6; i++)
      conv_check($sformatf("tbl%0d", i), tbl[i].v, tbl[i].eu, tbl[i].et, tbl[i].eh);

    // Change mid-conversion: 100 then 101
    set_value(8'd100);
    wait_rise(ok);
    if (ok) begin
      repeat (3) @(negedge clock);
      set_value(8'd101);
      wait_fall(len);
      chk("mid_busy_len", len + 3, 10);
      @(negedge clock);
      chk("mid_gap_one_cycle", bus4.busy, 1'b1);
      model(100, eu, et, eh);
      case (bus4.anodes)
        4'b1110: chk("mid_show100", bus4.segments, eu);
        4'b1101: chk("mid_show100", bus4.segments, et);
        4'b1011: chk("mid_show100", bus4.segments, eh);
        default: chk("mid_show100", bus4.segments, 8'hFF);
      endcase
      wait_fall(len);
      chk("mid_busy2_len", len, 10);
    end
    model(101, eu, et, eh);
    frame(su, st, sh, bad);
    chk("mid_units", su, eu);
    chk("mid_tens", st, et);
    chk("mid_hund", sh, eh);

    // Reset mid-conversion with 200
    set_value(8'd200);
    wait_rise(ok);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rstmid_segments", bus4.segments, 8'hFF);
    chk("rstmid_anodes", bus4.anodes, 4'hF);
    chk("rstmid_busy", bus4.busy, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    model(200, eu, et, eh);
    wait_rise(ok);
    if (ok) begin
      wait_fall(len);
      chk("rstmid_busy_len", len, 10);
    end
    frame(su, st, sh, bad);
    chk("rstmid_units", su, eu);
    chk("rstmid_tens", st, et);
    chk("rstmid_hund", sh, eh);

    // Random values against the decimal model
    cur = 200;
    for (int i = 0; i < 8; i++) begin
      do v = $urandom_range(1, 255); while (v == cur || v == 123);
      model(v, eu, et, eh);
      conv_check($sformatf("rnd%0d_v%0d", i, v), v[7:0], eu, et, eh);
      cur = v;
    end

    // Fast refresh: 3+ frames of the REFRESH_DIV=2 instance showing 123
    set_value(8'd123);
    wait_rise(ok);
    if (ok) wait_fall(len);
    repeat (2) @(negedge clock);
    model(123, eu, et, eh);
    aq.delete();
    sq.delete();
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      aq.push_back(bus2.anodes);
      sq.push_back(bus2.segments);
    end
    check_runs("wrap2", 2, aq, sq, eu, et, eh);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/press_display.md
# press_display

Downstream display stage for the press counter: consumes the 8-bit `nr_presses` value and drives a 4-digit, common-anode, multiplexed seven-segment display with its decimal value (0–255). The block has two parts:
- a sequential binary-to-BCD converter (shift-add-3, one bit per cycle);
- a refresh scanner that time-multiplexes the digits.

All outputs are registered. Leading zeros are blanked.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit. Legal range 2..2^20.
- `clock`  in  1  system clock. All state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `value`  in  8  binary count to display. Connected to `nr_presses`.
- `segments`  out  8  active-low cathodes: bit 0 = a … bit 6 = g, bit 7 = dp. Bit 7 is always 1.
- `anodes`  out  4  active-low digit enables: bit 0 = units, bit 1 = tens, bit 2 = hundreds, bit 3 = unused digit.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- **Reset state (while `reset`=0):**
  - `segments`=8'hFF, `anodes`=4'hF, `busy`=0.
  - BCD registers = 0, `last_value` = 0.
  - Digit index = 0, refresh counter = 0, converter in IDLE.
- **Converter FSM:** states IDLE, SHIFT, COMMIT.
  - IDLE: if `value` != `last_value`, load `value` into the shift register, clear the BCD scratch, set bit counter to 0, latch `value` into `last_value`, set `busy`=1, go to SHIFT.
  - SHIFT, once per cycle: first add 3 to each scratch BCD nibble that is ≥5, then shift {bcd, bin} left by 1. After 8 shifts go to COMMIT.
  - COMMIT: copy scratch into the displayed BCD registers (hundreds, tens, units), clear `busy`, return to IDLE.
  - Changes on `value` during SHIFT or COMMIT are ignored. On return to IDLE the compare is repeated, so the last stable value is always displayed eventually.
  - Width rule: hundreds ≤ 2, so the scratch BCD is 10 bits. No overflow is possible for 8-bit input.
- **Scanner:**
  - The refresh counter counts 0..`REFRESH_DIV`-1 and wraps.
  - On the cycle it equals `REFRESH_DIV`-1, the digit index advances 0→1→2→3→0.
  - Index 3 is always dark: `anodes`=4'hF, `segments`=8'hFF.
- **Digit pattern, `segments`[6:0] active-low (g..a):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- **Leading-zero blanking:**
  - Hundreds is blanked if it is 0.
  - Tens is blanked if hundreds = 0 and tens = 0.
  - Units is never blanked.
  - A blanked digit drives `segments`=8'hFF, but its anode is still asserted.
- The scanner reads only the committed BCD registers. It never displays a partial conversion.

## Timing
- Conversion latency: `value` changes before edge N (converter in IDLE).
  - Edge N: capture; `busy` rises.
  - Edges N+1..N+8: shifts.
  - Edge N+9: COMMIT edge, which leaves `busy`=1.
  - Edge N+10: new BCD registers visible, `busy` falls.
  - `busy` is high for exactly 10 cycles.
- Back-to-back changes: the next capture happens no earlier than the edge after `busy` falls.
- Scanner outputs:
  - `anodes` and `segments` update together on the edge where the index advances.
  - A committed BCD change appears on `segments` within one cycle, for whichever digit is currently lit.
  - Each digit stays lit for exactly `REFRESH_DIV` cycles. Full frame = 4×`REFRESH_DIV` cycles.
- First digit after reset release:
  - The first edge after release sets `anodes`=4'b1110, with `segments` showing units = 0 (pattern 8'hC0).
  - The index first advances after `REFRESH_DIV` cycles.
- Reset asserted mid-conversion: aborts immediately to the reset state. After release, the current `value` is reconverted if nonzero.
- `value`=0 after reset: no conversion is started (matches `last_value`). Display shows "0".

## Test plan
- **Reset/idle:** `REFRESH_DIV`=4, `value`=0, release reset.
  - `busy` never rises.
  - `anodes` cycles 1110,1101,1011,1111, each for 4 cycles.
  - `segments` = C0, FF, FF, FF.
- **Full-scale:** `value`=255.
  - `busy` is high for 10 cycles.
  - Then units and tens show 8'h92 (5), hundreds shows 8'hA4 (2).
- **Blanking:** `value`=7, then `value`=40.
  - For 7: units = F8, tens/hundreds = FF.
  - For 40: units = C0, tens = 99, hundreds = FF.
- **Change mid-conversion:** `value`=100, then 3 cycles later `value`=101.
  - The first conversion completes and shows 100.
  - A second `busy` pulse starts one cycle after the first ends.
  - Final display is 101.
- **Reset mid-conversion:** `value`=200, assert `reset` at cycle 4 of `busy`, release.
  - Outputs go to FF/F immediately while reset is held.
  - After release, a conversion runs and the display shows 200.
- **Refresh wrap:** `REFRESH_DIV`=2, `value`=123, observe 3 frames.
  - The strict 4-phase anode rotation holds, with 2 cycles per digit and no skipped or duplicated phase.
